// File: rtl/seq_det_monitor.sv
// seq_det_monitor
// Watches the detected pulse of a sequence detector. Each accepted
// detection is counted, timestamped into a small first-word-fall-through
// FIFO, and the spacing between the two most recent detections is measured.
//
// Parameters:
//   TS_W   width of the free-running timestamp and stored timestamps
//   CNT_W  width of det_count, last_gap and the internal gap counter
//   DEPTH  number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   det_in     detection pulse, one event per high cycle
//   enable     1 = events counted and logged, 0 = events ignored
//   clr        clears det_count, last_gap and overflow (FIFO untouched)
//   rd_en      pop request for the timestamp FIFO
//   ts_out     timestamp at the FIFO head, 0 when empty
//   ts_valid   FIFO not empty
//   fifo_full  FIFO holds DEPTH entries
//   overflow   sticky, an event was dropped because the FIFO was full
//   det_count  saturating count of accepted events
//   last_gap   saturating cycle distance between the two latest events
module seq_det_monitor #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             enable,
  input  logic             clr,
  input  logic             rd_en,
  output logic [TS_W-1:0]  ts_out,
  output logic             ts_valid,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] det_count,
  output logic [CNT_W-1:0] last_gap
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  // The gap counter only runs once a first event has been seen since
  // reset or clr; before that, an event just arms it.
  typedef enum logic {GAP_IDLE, GAP_RUN} gap_state_t;

  gap_state_t       gap_state;
  logic [CNT_W-1:0] gap_cnt;
  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;

  logic accept;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign accept = det_in & enable;
  assign empty  = (occ == '0);
  assign full   = (occ == OCC_FULL);
  assign pop    = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  assign ts_valid  = ~empty;
  assign fifo_full = full;
  assign ts_out    = empty ? '0 : mem[rd_ptr];

  // Storage has no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ts;
    end
  end

  // Free-running timestamp and FIFO pointers. Occupancy is tracked as a
  // separate count so full and empty are never ambiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        occ <= occ + (AW+1)'(1);
      end else if (pop && !push) begin
        occ <= occ - (AW+1)'(1);
      end
    end
  end

  // Statistics. clr wins over a same-cycle event here, although that event
  // still reaches the FIFO above. Overflow is not raised on a clr cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow  <= 1'b0;
      det_count <= '0;
      last_gap  <= '0;
      gap_cnt   <= '0;
      gap_state <= GAP_IDLE;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        if (det_count != CNT_MAX) begin
          det_count <= det_count + CNT_W'(1);
        end
        if (gap_state == GAP_RUN) begin
          last_gap <= (gap_cnt == CNT_MAX) ? CNT_MAX : gap_cnt + CNT_W'(1);
        end
        gap_cnt   <= '0;
        gap_state <= GAP_RUN;
      end else if (enable && gap_state == GAP_RUN && gap_cnt != CNT_MAX) begin
        gap_cnt <= gap_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_monitor.sv
// tb_seq_det_monitor
// Drives seq_det_monitor with directed scenarios and random traffic and
// compares every output each cycle against a queue-based reference model.
module tb_seq_det_monitor;

  localparam int TS_W    = 16;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 255;
  localparam int TS_MOD  = 65536;

  logic             clk;
  logic             rst;
  logic             det_in;
  logic             enable;
  logic             clr;
  logic             rd_en;
  logic [TS_W-1:0]  ts_out;
  logic             ts_valid;
  logic             fifo_full;
  logic             overflow;
  logic [CNT_W-1:0] det_count;
  logic [CNT_W-1:0] last_gap;

  int checks;
  int errors;

  // Reference model state: plain integers and a queue of timestamps.
  int m_ts;
  int m_q[$];
  int m_ovf;
  int m_cnt;
  int m_gap;
  int m_seen;
  int m_between;

  int saved_ts[$];

  seq_det_monitor #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .det_in    (det_in),
    .enable    (enable),
    .clr       (clr),
    .rd_en     (rd_en),
    .ts_out    (ts_out),
    .ts_valid  (ts_valid),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .det_count (det_count),
    .last_gap  (last_gap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the specification's rules, using the state before the edge.
  task automatic modelStep(input bit r, input bit d, input bit e, input bit c, input bit rd);
    bit acc;
    bit popq;
    bit wasfull;
    if (r) begin
      m_ts = 0;
      m_q.delete();
      m_ovf = 0;
      m_cnt = 0;
      m_gap = 0;
      m_seen = 0;
      m_between = 0;
      return;
    end
    acc = d && e;
    wasfull = (m_q.size() == DEPTH);
    popq = rd && (m_q.size() > 0);
    if (popq) void'(m_q.pop_front());
    if (acc && (!wasfull || popq)) m_q.push_back(m_ts);
    if (c) begin
      m_cnt = 0;
      m_gap = 0;
      m_ovf = 0;
      m_seen = 0;
      m_between = 0;
    end else begin
      if (acc && wasfull && !popq) m_ovf = 1;
      if (acc) begin
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (m_seen) m_gap = (m_between + 1 > CNT_MAX) ? CNT_MAX : m_between + 1;
        m_seen = 1;
        m_between = 0;
      end else if (e && m_seen) begin
        m_between++;
      end
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic compareAll();
    checkOutput("ts_valid", 32'(ts_valid), 32'(m_q.size() > 0));
    checkOutput("ts_out", 32'(ts_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    checkOutput("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("det_count", 32'(det_count), 32'(m_cnt));
    checkOutput("last_gap", 32'(last_gap), 32'(m_gap));
  endtask

  // Present inputs away from the edge, clock once, then compare #1 later.
  task automatic applyStimulus(input bit r, input bit d, input bit e, input bit c, input bit rd);
    rst = r;
    det_in = d;
    enable = e;
    clr = c;
    rd_en = rd;
    @(posedge clk);
    modelStep(r, d, e, c, rd);
    #1;
    compareAll();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    det_in = 1'b0;
    enable = 1'b0;
    clr = 1'b0;
    rd_en = 1'b0;
    #2;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("rst_valid", 32'(ts_valid), 32'd0);
    checkOutput("rst_count", 32'(det_count), 32'd0);

    // Events at timestamps 3 and 6.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, (m_ts == 3 || m_ts == 6), 1, 0, 0);
    end
    checkOutput("dir_count2", 32'(det_count), 32'd2);
    checkOutput("dir_gap3", 32'(last_gap), 32'd3);
    checkOutput("dir_head3", 32'(ts_out), 32'd3);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("dir_head6", 32'(ts_out), 32'd6);

    // Five events with no reads: full after four, overflow on the fifth.
    applyStimulus(1, 0, 0, 0, 0);
    saved_ts.delete();
    for (int i = 0; i < 5; i++) begin
      saved_ts.push_back(m_ts);
      applyStimulus(0, 1, 1, 0, 0);
      if (i == 3) checkOutput("dir_full4", 32'(fifo_full), 32'd1);
      if (i == 3) checkOutput("dir_noovf4", 32'(overflow), 32'd0);
    end
    checkOutput("dir_ovf5", 32'(overflow), 32'd1);
    checkOutput("dir_count5", 32'(det_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("dir_pop_order", 32'(ts_out), 32'(saved_ts[i]));
      applyStimulus(0, 0, 1, 0, 1);
    end
    checkOutput("dir_drained", 32'(ts_valid), 32'd0);

    // Full FIFO with simultaneous event and pop.
    applyStimulus(1, 0, 0, 0, 0);
    saved_ts.delete();
    for (int i = 0; i < 4; i++) begin
      saved_ts.push_back(m_ts);
      applyStimulus(0, 1, 1, 0, 0);
    end
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("dir_pp_ovf", 32'(overflow), 32'd0);
    checkOutput("dir_pp_full", 32'(fifo_full), 32'd1);
    checkOutput("dir_pp_head", 32'(ts_out), 32'(saved_ts[1]));

    // Saturation of det_count and last_gap.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dir_cnt_sat", 32'(det_count), 32'd255);
    for (int i = 0; i < 299; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dir_gap_sat", 32'(last_gap), 32'd255);

    // clr together with an event.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 1, 0, (i % 2) == 1);
      applyStimulus(0, 0, 1, 0, 1);
    end
    checkOutput("dir_count7", 32'(det_count), 32'd7);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    saved_ts.delete();
    saved_ts.push_back(m_ts);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("dir_clr_cnt", 32'(det_count), 32'd0);
    checkOutput("dir_clr_gap", 32'(last_gap), 32'd0);
    checkOutput("dir_clr_ovf", 32'(overflow), 32'd0);
    checkOutput("dir_clr_head", 32'(ts_out), 32'(saved_ts[0]));

    // Reset mid-operation, then disabled events.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("dir_pre_rst_cnt", 32'(det_count), 32'd3);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("dir_rst_valid", 32'(ts_valid), 32'd0);
    checkOutput("dir_rst_out", 32'(ts_out), 32'd0);
    checkOutput("dir_rst_cnt", 32'(det_count), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, (i % 2) == 0, 0, 0, 0);
    checkOutput("dir_dis_cnt", 32'(det_count), 32'd0);
    checkOutput("dir_dis_valid", 32'(ts_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(199) == 0,
                    $urandom_range(2) == 0,
                    $urandom_range(5) != 0,
                    $urandom_range(49) == 0,
                    $urandom_range(2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
